// File: rtl/display_source_mux.sv
// display_source_mux
//   Picks one of NUM_SRC packed BCD sources for the seven-segment decoders.
//   Supports stepping, direct load, auto-cycling on tick, a blanking interval
//   on every source change, freeze, and leading-zero suppression.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tick              one-cycle timing enable; dwell/blank count in ticks
//   enable            display enable (forces tag 0 and all digits dark)
//   src_data/src_tag  packed sources, source s at slice s
//   next/sel_load/sel_in  selection events (load > next > auto expiry)
//   auto_en, freeze, lz_suppress  mode controls
//   hex_tag, digits, blank_mask, cur_sel, switching  registered outputs
module display_source_mux #(
  parameter  int NUM_SRC     = 4,
  parameter  int DIGITS      = 4,
  parameter  int DWELL       = 5,
  parameter  int BLANK_TICKS = 1,
  localparam int SELW        = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic                        enable,
  input  logic [NUM_SRC*DIGITS*4-1:0] src_data,
  input  logic [NUM_SRC*4-1:0]        src_tag,
  input  logic                        next,
  input  logic                        sel_load,
  input  logic [SELW-1:0]             sel_in,
  input  logic                        auto_en,
  input  logic                        freeze,
  input  logic                        lz_suppress,
  output logic [3:0]                  hex_tag,
  output logic [DIGITS*4-1:0]         digits,
  output logic [DIGITS-1:0]           blank_mask,
  output logic [SELW-1:0]             cur_sel,
  output logic                        switching
);
  localparam int DW  = DIGITS * 4;
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BCW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [SELW:0]   NSRC       = (SELW+1)'(NUM_SRC);
  localparam logic [SELW-1:0] LAST_SEL   = SELW'(NUM_SRC - 1);
  localparam logic [DCW-1:0]  DWELL_LAST = DCW'(DWELL - 1);
  localparam logic [BCW-1:0]  BLANK_LAST = BCW'(BLANK_TICKS - 1);

  typedef enum logic {SHOW, BLANK} state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] cur_sel_q, cur_sel_d;
  logic [DCW-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [BCW-1:0]  blank_cnt_q, blank_cnt_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic [3:0]      tag_q, tag_d;          // selected tag before enable gating
  logic [3:0]      hex_tag_q, hex_tag_d;
  logic [DIGITS-1:0] blank_mask_q, blank_mask_d;
  logic            switching_q, switching_d;

  logic [SELW-1:0] sel_inc;
  logic            load_ok, expire, sel_evt;
  logic [DW-1:0]   src_slice;
  logic [3:0]      tag_slice;

  // Mark leading zero nibbles from the top down; digit 0 always stays lit.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [DW-1:0] d);
    logic seen;
    lz_mask = '0;
    seen    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (d[i*4 +: 4] != 4'h0) seen = 1'b1;
      lz_mask[i] = !seen;
    end
  endfunction

  always_comb begin
    sel_inc = (cur_sel_q == LAST_SEL) ? '0 : cur_sel_q + 1'b1;
    // An out-of-range load is dropped so lower-priority next still applies.
    load_ok = sel_load && ({1'b0, sel_in} < NSRC);
    expire  = (state_q == SHOW) && auto_en && !freeze && tick &&
              (dwell_cnt_q == DWELL_LAST);
    sel_evt = load_ok || next || expire;

    cur_sel_d   = cur_sel_q;
    state_d     = state_q;
    dwell_cnt_d = dwell_cnt_q;
    blank_cnt_d = blank_cnt_q;

    if (load_ok)              cur_sel_d = sel_in;
    else if (next || expire)  cur_sel_d = sel_inc;

    // An event swallows a coincident tick: both counters restart at 0.
    if (sel_evt) begin
      state_d     = BLANK;
      dwell_cnt_d = '0;
      blank_cnt_d = '0;
    end else if (state_q == BLANK) begin
      dwell_cnt_d = '0;
      if (tick) begin
        if (blank_cnt_q == BLANK_LAST) begin
          state_d     = SHOW;
          blank_cnt_d = '0;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
    end else begin
      if (!auto_en)            dwell_cnt_d = '0;
      else if (tick && !freeze) dwell_cnt_d = dwell_cnt_q + 1'b1;
    end

    // Output registers follow the next state so cur_sel and switching move together.
    src_slice = src_data[int'(cur_sel_d)*DW +: DW];
    tag_slice = src_tag[int'(cur_sel_d)*4 +: 4];

    digits_d = digits_q;
    tag_d    = tag_q;
    if (state_d == BLANK) begin
      digits_d = '0;
      tag_d    = '0;
    end else if (!freeze || state_q == BLANK) begin
      // First SHOW cycle after BLANK always loads, even when frozen.
      digits_d = src_slice;
      tag_d    = tag_slice;
    end

    if (!enable || state_d == BLANK) blank_mask_d = '1;
    else if (lz_suppress)            blank_mask_d = lz_mask(digits_d);
    else                             blank_mask_d = '0;

    hex_tag_d   = enable ? tag_d : 4'h0;
    switching_d = (state_d == BLANK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SHOW;
      cur_sel_q    <= '0;
      dwell_cnt_q  <= '0;
      blank_cnt_q  <= '0;
      digits_q     <= '0;
      tag_q        <= '0;
      hex_tag_q    <= '0;
      blank_mask_q <= '1;
      switching_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_sel_q    <= cur_sel_d;
      dwell_cnt_q  <= dwell_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
      digits_q     <= digits_d;
      tag_q        <= tag_d;
      hex_tag_q    <= hex_tag_d;
      blank_mask_q <= blank_mask_d;
      switching_q  <= switching_d;
    end
  end

  assign hex_tag    = hex_tag_q;
  assign digits     = digits_q;
  assign blank_mask = blank_mask_q;
  assign cur_sel    = cur_sel_q;
  assign switching  = switching_q;
endmodule
